// File: rtl/sift_orient_pkg.sv
// Shared definitions for the keypoint orientation-assignment stage.
//   NUM_BINS : number of orientation histogram bins
//   BIN_W    : width of a bin index
//   state_t  : controller states of orientation_histogram
package sift_orient_pkg;

  localparam int NUM_BINS = 8;
  localparam int BIN_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ARGMAX,
    DONE
  } state_t;

endpackage

// File: rtl/window_scanner.sv
// Window position generator for orientation_histogram.
// Walks signed offsets (dx,dy) over a (2R+1)x(2R+1) window, row-major
// (dx inner), and reports the absolute pixel position and whether it lies
// inside the image.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : reload offsets to (-R,-R)
//   advance        : step to the next window position
//   key_x, key_y   : keypoint the window is centred on
//   pos_x, pos_y   : absolute position (valid when in_image)
//   in_image       : current position lies inside the image
//   last           : current position is the final one (dx=dy=+R)
module window_scanner #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int R      = 2,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          advance,
  input  logic [XW-1:0] key_x,
  input  logic [YW-1:0] key_y,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          in_image,
  output logic          last
);

  localparam int OFF_W = $clog2(2*R+1) + 1;
  // Position arithmetic is done two bits wider than the widest operand so
  // both negative results and results past the far edge are representable.
  localparam int PXW = ((XW > OFF_W) ? XW : OFF_W) + 2;
  localparam int PYW = ((YW > OFF_W) ? YW : OFF_W) + 2;

  localparam logic signed [OFF_W-1:0] OFF_MIN = OFF_W'(-R);
  localparam logic signed [OFF_W-1:0] OFF_MAX = OFF_W'(R);
  localparam logic signed [OFF_W-1:0] OFF_ONE = OFF_W'(1);
  localparam logic signed [PXW-1:0]   X_LIM   = PXW'(WIDTH);
  localparam logic signed [PYW-1:0]   Y_LIM   = PYW'(HEIGHT);

  logic signed [OFF_W-1:0] dx;
  logic signed [OFF_W-1:0] dy;
  logic signed [PXW-1:0]   px;
  logic signed [PYW-1:0]   py;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx <= '0;
      dy <= '0;
    end else if (start) begin
      dx <= OFF_MIN;
      dy <= OFF_MIN;
    end else if (advance) begin
      if (dx == OFF_MAX) begin
        dx <= OFF_MIN;
        dy <= dy + OFF_ONE;
      end else begin
        dx <= dx + OFF_ONE;
      end
    end
  end

  // Keypoint is zero-extended, offset is sign-extended, then summed signed.
  always_comb begin
    px = $signed({{(PXW-XW){1'b0}}, key_x}) + $signed({{(PXW-OFF_W){dx[OFF_W-1]}}, dx});
    py = $signed({{(PYW-YW){1'b0}}, key_y}) + $signed({{(PYW-OFF_W){dy[OFF_W-1]}}, dy});
  end

  assign in_image = !px[PXW-1] && (px < X_LIM) && !py[PYW-1] && (py < Y_LIM);
  assign pos_x    = px[XW-1:0];
  assign pos_y    = py[YW-1:0];
  assign last     = (dx == OFF_MAX) && (dy == OFF_MAX);

endmodule

// File: rtl/orientation_histogram.sv
// Keypoint orientation-assignment stage.
// For each accepted keypoint, scans a (2R+1)x(2R+1) window, issues one
// orientation request per in-image pixel (one outstanding at a time),
// accumulates an 8-bin histogram from the returned bins and reports the
// dominant bin (ties go to the lowest index) with its count.
// Optional build macro HIST_SMOOTH_EN: the argmax compares and reports the
// circularly smoothed value h[i-1]+2*h[i]+h[i+1] instead of the raw count.
// Ports:
//   clk_in, rst_n_in           : clock, asynchronous active-low reset
//   key_x_in, key_y_in         : keypoint coordinates
//   key_valid_in               : keypoint strobe (accepted only when idle)
//   busy_out                   : high while not idle
//   center_addr_x/y_out        : request address to the orientation stage
//   center_valid_out           : request strobe
//   bin_in, bin_valid_in       : orientation bin returned for the request
//   dominant_bin_out           : winning bin
//   dominant_count_out         : winning bin value
//   key_x_out, key_y_out       : keypoint echo for the result
//   hist_valid_out             : result strobe
module orientation_histogram
  import sift_orient_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int HEIGHT        = 64,
  parameter int WINDOW_RADIUS = 2,
  parameter int CNT_W         = $clog2((2*WINDOW_RADIUS+1)**2+1)
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [$clog2(WIDTH)-1:0]  key_x_in,
  input  logic [$clog2(HEIGHT)-1:0] key_y_in,
  input  logic                      key_valid_in,
  output logic                      busy_out,
  output logic [$clog2(WIDTH)-1:0]  center_addr_x_out,
  output logic [$clog2(HEIGHT)-1:0] center_addr_y_out,
  output logic                      center_valid_out,
  input  logic [2:0]                bin_in,
  input  logic                      bin_valid_in,
  output logic [2:0]                dominant_bin_out,
  output logic [CNT_W+1:0]          dominant_count_out,
  output logic [$clog2(WIDTH)-1:0]  key_x_out,
  output logic [$clog2(HEIGHT)-1:0] key_y_out,
  output logic                      hist_valid_out
);

  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int VAL_W = CNT_W + 2;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [BIN_W-1:0] BIN_ONE  = BIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state;
  state_t next_state;

  logic [XW-1:0]    key_x_q;
  logic [YW-1:0]    key_y_q;
  logic [CNT_W-1:0] hist [NUM_BINS];

  logic [XW-1:0]    pos_x;
  logic [YW-1:0]    pos_y;
  logic             in_image;
  logic             last;

  logic             accept;
  logic             issue_req;
  logic             scan_advance;
  logic             hist_inc;
  logic             argmax_step;

  logic [XW-1:0]    req_x_q;
  logic [YW-1:0]    req_y_q;
  logic             req_valid_q;

  logic [BIN_W-1:0] arg_idx;
  logic [BIN_W-1:0] prev_idx;
  logic [BIN_W-1:0] next_idx;
  logic [BIN_W-1:0] best_bin;
  logic [VAL_W-1:0] best_val;
  logic [VAL_W-1:0] cand;
  logic             win;

  logic [BIN_W-1:0] res_bin;
  logic [VAL_W-1:0] res_val;
  logic [XW-1:0]    res_x;
  logic [YW-1:0]    res_y;

  window_scanner #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .R      (WINDOW_RADIUS),
    .XW     (XW),
    .YW     (YW)
  ) u_scanner (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .start    (accept),
    .advance  (scan_advance),
    .key_x    (key_x_q),
    .key_y    (key_y_q),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .in_image (in_image),
    .last     (last)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (key_valid_in) next_state = ISSUE;
      ISSUE: begin
        if (in_image)  next_state = WAIT;
        else if (last) next_state = ARGMAX;
      end
      WAIT: begin
        if (bin_valid_in) next_state = last ? ARGMAX : ISSUE;
      end
      ARGMAX:  if (arg_idx == LAST_BIN) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Out-of-image positions are skipped in ISSUE; in-image ones advance only
  // once their bin has come back, which keeps one request outstanding.
  always_comb begin
    accept         = (state == IDLE) && key_valid_in;
    issue_req      = (state == ISSUE) && in_image;
    hist_inc       = (state == WAIT) && bin_valid_in;
    scan_advance   = ((state == ISSUE) && !in_image) || hist_inc;
    argmax_step    = (state == ARGMAX);
    busy_out       = (state != IDLE);
    hist_valid_out = (state == DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      key_x_q <= '0;
      key_y_q <= '0;
    end else if (accept) begin
      key_x_q <= key_x_in;
      key_y_q <= key_y_in;
    end
  end

  // Request address is registered together with its strobe and then held
  // until the next request.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      req_x_q     <= '0;
      req_y_q     <= '0;
      req_valid_q <= 1'b0;
    end else begin
      req_valid_q <= issue_req;
      if (issue_req) begin
        req_x_q <= pos_x;
        req_y_q <= pos_y;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_BINS; i++) hist[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_BINS; i++) hist[i] <= '0;
    end else if (hist_inc && (hist[bin_in] != CNT_MAX)) begin
      hist[bin_in] <= hist[bin_in] + CNT_ONE;
    end
  end

  // Neighbour indices wrap modulo 8 through the natural 3-bit overflow.
  always_comb begin
    prev_idx = arg_idx - BIN_ONE;
    next_idx = arg_idx + BIN_ONE;
`ifdef HIST_SMOOTH_EN
    cand = {2'b00, hist[prev_idx]} + {1'b0, hist[arg_idx], 1'b0} + {2'b00, hist[next_idx]};
`else
    cand = {2'b00, hist[arg_idx]};
`endif
    win = (arg_idx == '0) || (cand > best_val);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      arg_idx  <= '0;
      best_bin <= '0;
      best_val <= '0;
    end else if (accept) begin
      arg_idx <= '0;
    end else if (argmax_step) begin
      arg_idx <= next_idx;
      if (win) begin
        best_bin <= arg_idx;
        best_val <= cand;
      end
    end
  end

  // The final comparison is folded straight into the result registers so the
  // result is already stable during the DONE cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      res_bin <= '0;
      res_val <= '0;
      res_x   <= '0;
      res_y   <= '0;
    end else if (argmax_step && (arg_idx == LAST_BIN)) begin
      res_bin <= win ? arg_idx : best_bin;
      res_val <= win ? cand : best_val;
      res_x   <= key_x_q;
      res_y   <= key_y_q;
    end
  end

  assign center_addr_x_out  = req_x_q;
  assign center_addr_y_out  = req_y_q;
  assign center_valid_out   = req_valid_q;
  assign dominant_bin_out   = res_bin;
  assign dominant_count_out = res_val;
  assign key_x_out          = res_x;
  assign key_y_out          = res_y;

endmodule

// File: tb/tb_orientation_histogram.sv
// Self-checking bench for orientation_histogram.
// A stub orientation stage answers each request after a programmable
// latency; a reference model (window enumeration and histogram argmax with
// plain arithmetic) predicts the request sequence and the result.
// Honours HIST_SMOOTH_EN the same way the design does.
module tb_orientation_histogram;

  localparam int XW = 6;
  localparam int YW = 6;
  localparam int R  = 2;
  localparam int VW = 7;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [XW-1:0] key_x_in;
  logic [YW-1:0] key_y_in;
  logic          key_valid_in;
  logic          busy_out;
  logic [XW-1:0] center_addr_x_out;
  logic [YW-1:0] center_addr_y_out;
  logic          center_valid_out;
  logic [2:0]    bin_in;
  logic          bin_valid_in;
  logic [2:0]    dominant_bin_out;
  logic [VW-1:0] dominant_count_out;
  logic [XW-1:0] key_x_out;
  logic [YW-1:0] key_y_out;
  logic          hist_valid_out;

  always #5 clk_in = ~clk_in;

  orientation_histogram dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .key_x_in           (key_x_in),
    .key_y_in           (key_y_in),
    .key_valid_in       (key_valid_in),
    .busy_out           (busy_out),
    .center_addr_x_out  (center_addr_x_out),
    .center_addr_y_out  (center_addr_y_out),
    .center_valid_out   (center_valid_out),
    .bin_in             (bin_in),
    .bin_valid_in       (bin_valid_in),
    .dominant_bin_out   (dominant_bin_out),
    .dominant_count_out (dominant_count_out),
    .key_x_out          (key_x_out),
    .key_y_out          (key_y_out),
    .hist_valid_out     (hist_valid_out)
  );

  typedef struct {
    int kx, ky, mode, cbin, lat;
    int exp_bin, exp_raw, exp_smooth, exp_n;
  } vec_t;

  int passed = 0;
  int total  = 0;

  int model_hist [8];
  int req_x [$];
  int req_y [$];
  int seq_a [25];
  int seq_b [25];
  int stub_mode, stub_cbin, stub_lat;
  int outstanding, overlap_errs;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int pick_count(input int raw, input int smooth);
`ifdef HIST_SMOOTH_EN
    return smooth;
`else
    return raw + 0 * smooth;
`endif
  endfunction

  function automatic void model_argmax(output int b, output int v);
    int vals [8];
    for (int i = 0; i < 8; i++) begin
`ifdef HIST_SMOOTH_EN
      vals[i] = model_hist[(i + 7) % 8] + 2 * model_hist[i] + model_hist[(i + 1) % 8];
`else
      vals[i] = model_hist[i];
`endif
    end
    b = 0;
    v = vals[0];
    for (int i = 1; i < 8; i++) if (vals[i] > v) begin b = i; v = vals[i]; end
  endfunction

  // Stub orientation stage: answers each request once, after stub_lat cycles.
  initial begin
    int b, lat, idx;
    bin_valid_in = 1'b0;
    bin_in = '0;
    forever begin
      @(posedge clk_in); #1;
      if (center_valid_out) begin
        req_x.push_back(int'(center_addr_x_out));
        req_y.push_back(int'(center_addr_y_out));
        idx = req_x.size() - 1;
        if (idx > 24) idx = 0;
        case (stub_mode)
          0: b = stub_cbin;
          1: b = seq_a[idx];
          2: b = seq_b[idx];
          default: b = int'($urandom_range(0, 7));
        endcase
        model_hist[b]++;
        lat = (stub_lat == 0) ? int'($urandom_range(1, 6)) : stub_lat;
        repeat (lat - 1) begin @(posedge clk_in); #1; end
        bin_in = b[2:0];
        bin_valid_in = 1'b1;
        @(posedge clk_in); #1;
        bin_valid_in = 1'b0;
      end
    end
  end

  // Counts any request issued while a previous one is still unanswered.
  initial begin
    outstanding = 0;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) outstanding = 0;
      else begin
        if (center_valid_out) begin
          if (outstanding != 0) overlap_errs++;
          outstanding++;
        end
        if (bin_valid_in && outstanding > 0) outstanding--;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, int'(busy_out), 0);
    check({tag, "_cvalid"}, int'(center_valid_out), 0);
    check({tag, "_caddr"}, int'({center_addr_x_out, center_addr_y_out}), 0);
    check({tag, "_hvalid"}, int'(hist_valid_out), 0);
    check({tag, "_dom"}, int'({dominant_bin_out, dominant_count_out}), 0);
    check({tag, "_keyecho"}, int'({key_x_out, key_y_out}), 0);
  endtask

  task automatic applyStimulus(input int kx, input int ky, input int mode,
                               input int cbin, input int lat);
    for (int i = 0; i < 8; i++) model_hist[i] = 0;
    req_x.delete();
    req_y.delete();
    overlap_errs = 0;
    stub_mode = mode;
    stub_cbin = cbin;
    stub_lat  = lat;
    @(negedge clk_in);
    key_x_in = kx[XW-1:0];
    key_y_in = ky[YW-1:0];
    key_valid_in = 1'b1;
    @(negedge clk_in);
    key_valid_in = 1'b0;
  endtask

  task automatic checkOutput(input int kx, input int ky,
                             output int got_bin, output int got_cnt, output int got_n);
    int cycles = 0;
    int eb, ec, mism, n;
    bit seen = 0;
    got_bin = -1;
    got_cnt = -1;
    while (cycles < 3000 && !seen) begin
      if (hist_valid_out) seen = 1;
      else begin @(negedge clk_in); cycles++; end
    end
    check("result_seen", int'(seen), 1);
    if (seen) begin
      got_bin = int'(dominant_bin_out);
      got_cnt = int'(dominant_count_out);
      model_argmax(eb, ec);
      check("dom_bin", got_bin, eb);
      check("dom_count", got_cnt, ec);
      check("echo_x", int'(key_x_out), kx);
      check("echo_y", int'(key_y_out), ky);
      @(negedge clk_in);
      check("hvalid_pulse", int'(hist_valid_out), 0);
      check("idle_after", int'(busy_out), 0);
      check("result_hold", int'(dominant_bin_out), got_bin);
    end else begin
      rst_n_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_n_in = 1'b1;
    end
    mism = 0;
    n = 0;
    for (int dy = -R; dy <= R; dy++) begin
      for (int dx = -R; dx <= R; dx++) begin
        if (kx + dx >= 0 && kx + dx < 64 && ky + dy >= 0 && ky + dy < 64) begin
          if (n >= req_x.size()) mism++;
          else if (req_x[n] != kx + dx || req_y[n] != ky + dy) mism++;
          n++;
        end
      end
    end
    got_n = req_x.size();
    check("req_count", got_n, n);
    check("req_order", mism, 0);
    check("one_outstanding", overlap_errs, 0);
  endtask

  vec_t vecs [7];

  initial begin
    int gb, gc, gn, guard;
    for (int i = 0; i < 25; i++) begin
      seq_a[i] = (i < 12) ? 2 : ((i < 24) ? 6 : 0);
      seq_b[i] = (i < 10) ? 0 : ((i < 18) ? 1 : 7);
    end
    vecs[0] = '{10, 10, 0, 3, 5, 3, 25, 50, 25};
    vecs[1] = '{ 0,  0, 0, 4, 2, 4,  9, 18,  9};
    vecs[2] = '{63, 63, 0, 5, 1, 5,  9, 18,  9};
    vecs[3] = '{ 0, 30, 0, 7, 3, 7, 15, 30, 15};
    vecs[4] = '{62,  1, 0, 0, 1, 0, 16, 32, 16};
    vecs[5] = '{10, 10, 1, 0, 2, 2, 12, 24, 25};
    vecs[6] = '{10, 10, 2, 0, 3, 0, 10, 35, 25};

    rst_n_in = 1'b0;
    key_x_in = '0;
    key_y_in = '0;
    key_valid_in = 1'b0;
    stub_mode = 0; stub_cbin = 0; stub_lat = 1;
    overlap_errs = 0;
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset");
    rst_n_in = 1'b1;
    @(negedge clk_in);

    for (int t = 0; t < 7; t++) begin
      applyStimulus(vecs[t].kx, vecs[t].ky, vecs[t].mode, vecs[t].cbin, vecs[t].lat);
      checkOutput(vecs[t].kx, vecs[t].ky, gb, gc, gn);
      check($sformatf("tbl%0d_bin", t), gb, vecs[t].exp_bin);
      check($sformatf("tbl%0d_count", t), gc, pick_count(vecs[t].exp_raw, vecs[t].exp_smooth));
      check($sformatf("tbl%0d_nreq", t), gn, vecs[t].exp_n);
    end

    // Keypoint strobe during WAIT must be dropped.
    applyStimulus(10, 10, 0, 6, 4);
    guard = 0;
    while (!center_valid_out && guard < 200) begin @(negedge clk_in); guard++; end
    check("ign_reached_wait", int'(center_valid_out), 1);
    key_x_in = 6'd30;
    key_y_in = 6'd30;
    key_valid_in = 1'b1;
    @(negedge clk_in);
    key_valid_in = 1'b0;
    checkOutput(10, 10, gb, gc, gn);
    check("ign_bin", gb, 6);
    applyStimulus(30, 30, 0, 5, 2);
    checkOutput(30, 30, gb, gc, gn);
    check("after_ign_count", gc, pick_count(25, 50));

    // Asynchronous reset in the middle of a WAIT.
    applyStimulus(10, 10, 0, 1, 6);
    guard = 0;
    while (req_x.size() < 3 && guard < 500) begin @(negedge clk_in); guard++; end
    check("rst_reached_wait", int'(busy_out), 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (20) @(negedge clk_in);
    check("midrst_stays_idle", int'(busy_out), 0);
    applyStimulus(10, 10, 0, 1, 2);
    checkOutput(10, 10, gb, gc, gn);
    check("fresh_bin", gb, 1);
    check("fresh_count", gc, pick_count(25, 50));

    // Random keypoints and random bins against the reference model.
    for (int t = 0; t < 6; t++) begin
      int kx, ky;
      kx = int'($urandom_range(0, 63));
      ky = int'($urandom_range(0, 63));
      applyStimulus(kx, ky, 3, 0, 0);
      checkOutput(kx, ky, gb, gc, gn);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
